// File: rtl/obstacle_manager.sv
// N-slot obstacle engine: frame-tick spawn/scroll/retire, speed ramp and per-pixel hit query.
// Optional `define OBSTACLE_PASS_CNT_EN adds passed_cnt_o, a saturating count of retired obstacles.
module obstacle_manager #(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_X      = 640,
  parameter int GROUND_Y     = 400,
  parameter int SPAWN_THRESH = 24,
  parameter int MIN_GAP      = 40,
  parameter int INIT_SPEED   = 2,
  parameter int MAX_SPEED    = 8,
  parameter int SPEED_STEP   = 600
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 run_i,
  input  logic                 next_frame_i,
  input  logic [15:0]          rand_i,
  input  logic [9:0]           pixel_x_i,
  input  logic [9:0]           pixel_y_i,
  output logic                 pixel_o,
  output logic [1:0]           pixel_type_o,
  output logic [NUM_SLOTS-1:0] active_o,
  output logic [3:0]           speed_o,
  output logic                 spawn_o
`ifdef OBSTACLE_PASS_CNT_EN
  , output logic [7:0]         passed_cnt_o
`endif
);

  localparam logic [9:0]  SPAWN_X_C    = 10'(SPAWN_X);
  localparam logic [7:0]  THRESH_C     = 8'(SPAWN_THRESH);
  localparam logic [7:0]  GAP_C        = 8'(MIN_GAP);
  localparam logic [3:0]  INIT_SPEED_C = 4'(INIT_SPEED);
  localparam logic [3:0]  MAX_SPEED_C  = 4'(MAX_SPEED);
  localparam logic [15:0] STEP_LAST_C  = 16'(SPEED_STEP - 1);
  localparam logic [10:0] GY_C         = 11'(GROUND_Y);

  function automatic logic [3:0] speed_inc_sat(input logic [3:0] s);
    return (s >= MAX_SPEED_C) ? s : s + 4'd1;
  endfunction

  function automatic logic [7:0] cnt_add_sat(input logic [7:0] c, input logic [3:0] n);
    logic [8:0] sum;
    sum = {1'b0, c} + {5'b0, n};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [10:0] box_w(input logic [1:0] t);
    case (t)
      2'd0:    return 11'd16;
      2'd1:    return 11'd24;
      default: return 11'd32;
    endcase
  endfunction

  function automatic logic [10:0] box_h(input logic [1:0] t);
    case (t)
      2'd0:    return 11'd32;
      2'd1:    return 11'd48;
      default: return 11'd16;
    endcase
  endfunction

  function automatic logic [10:0] box_top(input logic [1:0] t);
    case (t)
      2'd0:    return GY_C - 11'd32;
      2'd1:    return GY_C - 11'd48;
      2'd2:    return GY_C - 11'd60;
      default: return GY_C - 11'd100;
    endcase
  endfunction

  logic [NUM_SLOTS-1:0] valid_q, valid_d, alloc_oh;
  logic [9:0]           x_q    [NUM_SLOTS];
  logic [9:0]           x_d    [NUM_SLOTS];
  logic [1:0]           type_q [NUM_SLOTS];
  logic [1:0]           type_d [NUM_SLOTS];
  logic [7:0]           gap_q, gap_d;
  logic [15:0]          frame_q, frame_d;
  logic [3:0]           speed_q, speed_d;
  logic                 spawn_q, spawn_d;
  logic                 tick, spawn_ok, found;
`ifdef OBSTACLE_PASS_CNT_EN
  logic [7:0]           passed_q, passed_d;
  logic [3:0]           n_retire;
`endif

  always_comb begin
    tick      = next_frame_i & run_i;
    valid_d   = valid_q;
    x_d       = x_q;
    type_d    = type_q;
    gap_d     = gap_q;
    frame_d   = frame_q;
    speed_d   = speed_q;
    found     = 1'b0;
    alloc_oh  = '0;
`ifdef OBSTACLE_PASS_CNT_EN
    passed_d  = passed_q;
    n_retire  = 4'd0;
`endif
    // Allocation sees only slots free before this tick; same-tick retirements wait a tick.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      alloc_oh[i] = !valid_q[i] && !found;
      if (!valid_q[i]) found = 1'b1;
    end
    spawn_ok = tick && (gap_q == 8'd0) && (rand_i[7:0] < THRESH_C) && found;
    spawn_d  = spawn_ok;
    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (spawn_ok && alloc_oh[i]) begin
          valid_d[i] = 1'b1;
          x_d[i]     = SPAWN_X_C;
          type_d[i]  = rand_i[9:8];
        end else if (valid_q[i]) begin
          if (x_q[i] <= {6'b0, speed_q}) begin
            valid_d[i] = 1'b0;
`ifdef OBSTACLE_PASS_CNT_EN
            n_retire   = n_retire + 4'd1;
`endif
          end else begin
            x_d[i] = x_q[i] - {6'b0, speed_q};
          end
        end
      end
      if (spawn_ok)            gap_d = GAP_C + {4'b0, rand_i[13:10]};
      else if (gap_q != 8'd0)  gap_d = gap_q - 8'd1;
      if (frame_q == STEP_LAST_C) begin
        frame_d = 16'd0;
        speed_d = speed_inc_sat(speed_q);
      end else begin
        frame_d = frame_q + 16'd1;
      end
`ifdef OBSTACLE_PASS_CNT_EN
      passed_d = cnt_add_sat(passed_q, n_retire);
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]    <= '0;
        type_q[i] <= '0;
      end
      gap_q    <= '0;
      frame_q  <= '0;
      speed_q  <= INIT_SPEED_C;
      spawn_q  <= 1'b0;
`ifdef OBSTACLE_PASS_CNT_EN
      passed_q <= '0;
`endif
    end else begin
      valid_q  <= valid_d;
      x_q      <= x_d;
      type_q   <= type_d;
      gap_q    <= gap_d;
      frame_q  <= frame_d;
      speed_q  <= speed_d;
      spawn_q  <= spawn_d;
`ifdef OBSTACLE_PASS_CNT_EN
      passed_q <= passed_d;
`endif
    end
  end

  logic        pix_hit;
  logic [1:0]  pix_type;
  logic [10:0] px, py, xr, top;

  // Scan from the top index down so the lowest hit slot has the final say on the type.
  always_comb begin
    pix_hit  = 1'b0;
    pix_type = 2'd0;
    px       = {1'b0, pixel_x_i};
    py       = {1'b0, pixel_y_i};
    xr       = '0;
    top      = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      xr  = {1'b0, x_q[i]};
      top = box_top(type_q[i]);
      if (valid_q[i] && (px + box_w(type_q[i]) >= xr) && (px < xr) &&
          (py >= top) && (py < top + box_h(type_q[i]))) begin
        pix_hit  = 1'b1;
        pix_type = type_q[i];
      end
    end
  end

  assign pixel_o      = pix_hit;
  assign pixel_type_o = pix_type;
  assign active_o     = valid_q;
  assign speed_o      = speed_q;
  assign spawn_o      = spawn_q;
`ifdef OBSTACLE_PASS_CNT_EN
  assign passed_cnt_o = passed_q;
`endif

endmodule

// File: tb/tb_obstacle_manager.sv
// Randomized bench for obstacle_manager against a slot-list reference model.
module tb_obstacle_manager;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_i, clear_i, run_i, next_frame_i;
  logic [15:0]  rand_i;
  logic [9:0]   pixel_x_i, pixel_y_i;
  logic         pixel_o, spawn_o;
  logic [1:0]   pixel_type_o;
  logic [N-1:0] active_o;
  logic [3:0]   speed_o;
`ifdef OBSTACLE_PASS_CNT_EN
  logic [7:0]   passed_cnt_o;
`endif

  obstacle_manager dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .run_i(run_i),
    .next_frame_i(next_frame_i), .rand_i(rand_i),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
    .pixel_o(pixel_o), .pixel_type_o(pixel_type_o),
    .active_o(active_o), .speed_o(speed_o), .spawn_o(spawn_o)
`ifdef OBSTACLE_PASS_CNT_EN
    , .passed_cnt_o(passed_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int BW[4]  = '{16, 24, 32, 32};
  int BH[4]  = '{32, 48, 16, 16};
  int TOP[4] = '{368, 352, 340, 300};

  int m_x[N], m_t[N];
  bit m_v[N];
  int m_gap, m_frame, m_speed, m_spawn, m_passed;
  int n_vec = 0, n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_x[i] = 0; m_t[i] = 0; end
    m_gap = 0; m_frame = 0; m_speed = 2; m_spawn = 0; m_passed = 0;
  endtask

  task automatic model_step(input bit nf, input bit run, input logic [15:0] rnd, input bit clr);
    int first_free, retired;
    if (clr) begin model_reset(); return; end
    m_spawn = 0;
    if (!(nf && run)) return;
    first_free = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_v[i]) first_free = i;
    retired = 0;
    for (int i = 0; i < N; i++)
      if (m_v[i]) begin
        if (m_x[i] <= m_speed) begin m_v[i] = 0; retired++; end
        else m_x[i] = m_x[i] - m_speed;
      end
    if (m_gap == 0 && int'(rnd[7:0]) < 24 && first_free >= 0) begin
      m_v[first_free] = 1; m_x[first_free] = 640; m_t[first_free] = int'(rnd[9:8]);
      m_gap = 40 + int'(rnd[13:10]); m_spawn = 1;
    end else if (m_gap > 0) m_gap--;
    m_frame++;
    if (m_frame == 600) begin m_frame = 0; if (m_speed < 8) m_speed++; end
    m_passed = (m_passed + retired > 255) ? 255 : m_passed + retired;
  endtask

  task automatic model_pixel(input int px, input int py, output int hit, output int typ);
    hit = 0; typ = 0;
    for (int i = 0; i < N; i++)
      if (m_v[i] && px >= m_x[i] - BW[m_t[i]] && px < m_x[i] &&
          py >= TOP[m_t[i]] && py < TOP[m_t[i]] + BH[m_t[i]]) begin
        hit = 1; typ = m_t[i]; break;
      end
  endtask

  task automatic check_pixel(input int px, input int py);
    int eh, et;
    pixel_x_i = 10'(px); pixel_y_i = 10'(py);
    #1;
    model_pixel(px, py, eh, et);
    check_eq("pix_hit", int'(pixel_o), eh);
    check_eq("pix_type", int'(pixel_type_o), et);
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  task automatic compare_all();
    logic [N-1:0] av;
    int s, tries;
    for (int i = 0; i < N; i++) av[i] = m_v[i];
    check_eq("active", int'(active_o), int'(av));
    check_eq("speed", int'(speed_o), m_speed);
    check_eq("spawn", int'(spawn_o), m_spawn);
`ifdef OBSTACLE_PASS_CNT_EN
    check_eq("passed", int'(passed_cnt_o), m_passed);
`endif
    check_pixel($urandom_range(0, 700), $urandom_range(280, 420));
    s = -1; tries = 0;
    while (s < 0 && tries < 8) begin
      int c = $urandom_range(0, N - 1);
      if (m_v[c]) s = c;
      tries++;
    end
    if (s >= 0)
      check_pixel(clamp(m_x[s] - BW[m_t[s]] - 2 + $urandom_range(0, BW[m_t[s]] + 3)),
                  clamp(TOP[m_t[s]] - 2 + $urandom_range(0, BH[m_t[s]] + 3)));
  endtask

  task automatic cyc(input bit nf, input bit run, input logic [15:0] rnd, input bit clr);
    next_frame_i = nf; run_i = run; rand_i = rnd; clear_i = clr;
    @(posedge clk);
    model_step(nf, run, rnd, clr);
    #1;
    next_frame_i = 1'b0; clear_i = 1'b0;
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int idle, guard;
    rst_i = 1'b1; clear_i = 1'b0; run_i = 1'b0; next_frame_i = 1'b0;
    rand_i = '0; pixel_x_i = '0; pixel_y_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_active", int'(active_o), 0);
    check_eq("rst_speed", int'(speed_o), 2);
    check_eq("rst_spawn", int'(spawn_o), 0);
    check_pixel(620, 345);
    check_pixel(0, 0);
    check_pixel(639, 399);
    rst_i = 1'b0;

    repeat (5) cyc(1, 0, 16'h0000, 0);
    check_eq("frozen_none", int'(active_o), 0);

    cyc(1, 1, 16'h0200, 0);
    check_eq("spawn_pulse", int'(spawn_o), 1);
    check_eq("spawn_slot0", int'(active_o), 1);
    check_pixel(639, 345);
    check_pixel(640, 345);
    cyc(1, 1, 16'hFFFF, 0);
    check_eq("no_respawn", int'(spawn_o), 0);
    check_pixel(620, 345);
    check_eq("move_hit", int'(pixel_o), 1);
    check_eq("move_type", int'(pixel_type_o), 2);

    idle = 1; guard = 0;
    while (guard < 100) begin
      cyc(1, 1, 16'h0000, 0);
      guard++;
      if (spawn_o) break;
      idle++;
    end
    check_eq("gap_idle_ticks", idle, 40);
    check_eq("gap_slot1", int'(active_o), 3);

    guard = 0;
    while (!(m_v[0] && m_v[1] && m_v[2] && m_v[3]) && guard < 400) begin
      cyc(1, 1, 16'h0100, 0); guard++;
    end
    guard = 0;
    while (m_gap != 0 && guard < 100) begin cyc(1, 1, 16'h0100, 0); guard++; end
    check_eq("full_active", int'(active_o), 15);
    cyc(1, 1, 16'h0100, 0);
    check_eq("full_drop", int'(spawn_o), 0);
    guard = 0;
    while (m_v[0] && guard < 600) begin cyc(1, 1, 16'h0300, 0); guard++; end
    check_eq("retire_slot0", int'(active_o[0]), 0);
    check_eq("retire_no_spawn", int'(spawn_o), 0);
    cyc(1, 1, 16'h0300, 0);
    check_eq("realloc_slot0", int'(active_o[0]), 1);
    check_eq("realloc_pulse", int'(spawn_o), 1);

    repeat (100) cyc(1, 0, 16'h0000, 0);

    cyc(1, 1, 16'h0000, 1);
    repeat (600) cyc(1, 1, 16'($urandom), 0);
    check_eq("speed_600", int'(speed_o), 3);
    repeat (5400) cyc(1, 1, 16'($urandom), 0);
    check_eq("speed_sat", int'(speed_o), 8);
    repeat (37) cyc(1, 1, 16'($urandom), 0);
    cyc(1, 1, 16'h0000, 1);
    check_eq("clear_speed", int'(speed_o), 2);
    check_eq("clear_active", int'(active_o), 0);

    repeat (1500)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 16'($urandom),
          $urandom_range(0, 999) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
